fre_word_sequencer: RTL and testbench
=====================================

// Module: fre_word_sequencer
// PURPOSE
//  Key-driven sequencer for the DDS frequency word: debounces four push keys and arbitrates them.
//  Applies saturating coarse/fine steps with auto-repeat on hold.
//  Hands each new word to the DDS loader over a valid/ready handshake.
//  Sits between the board keys/LEDs and the DDS phase-accumulator config port.
// PARAMETERS
//  DEB_CYCLES    1000000  stable-level cycles needed to accept a press or release (20 ms @ 50 MHz)
//  REPEAT_DELAY  25000000 held cycles after first step before auto-repeat starts
//  REPEAT_PERIOD 5000000  cycles between auto-repeat steps
//  STEP_COARSE   100      step for key[0] (+) / key[1] (-)
//  STEP_FINE     10       step for key[2] (+) / key[3] (-)
//  FW_INIT       10       frequency word after reset
//  FW_MIN        0        lower clamp
//  FW_MAX        65535    upper clamp
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  key       in   4   raw active-high keys, asynchronous to clk
//  fw_ready  in   1   DDS loader accepts fre_word this cycle when fw_valid=1
//  fre_word  out  16  frequency word offered/committed to the DDS
//  fw_valid  out  1   fre_word holds a new value awaiting acceptance
//  led       out  4   led[i] toggles on each effective step caused by key[i]
//  busy      out  1   high in every state except IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge, any state):
//    - fre_word=FW_INIT, fw_valid=0, led=0, busy=1, all counters 0, state=INIT.
//  - Key sampling: key passes a 2-flop synchronizer; FSM acts on the synchronized value ks.
//    Latency from pin to ks is 2 cycles.
//  - FSM states: INIT, IDLE, DEB_PRESS, APPLY, WAIT_ACK, HOLD, DEB_REL.
//  - INIT: assert fw_valid with FW_INIT (announces the reset word); go to WAIT_ACK. No LED change.
//  - IDLE:
//    - If any ks bit is high, latch act = lowest set index (key[0] highest priority); go DEB_PRESS; cnt=0.
//  - DEB_PRESS:
//    - If ks[act]=0, go to IDLE with no action.
//    - Otherwise count; when cnt reaches DEB_CYCLES-1, go to APPLY.
//  - APPLY (1 cycle): compute nxt in 17 bits.
//    - Increment: min(fre_word+step, FW_MAX). Decrement: max(fre_word-step, FW_MIN), with underflow detected.
//    - If nxt != fre_word: load fre_word=nxt, set fw_valid=1, toggle led[act], go to WAIT_ACK.
//    - If nxt == fre_word (pinned at a clamp): no update, no LED toggle, go to HOLD.
//  - WAIT_ACK:
//    - fre_word and fw_valid are held stable until the cycle with fw_ready=1.
//    - On that cycle fw_valid drops at the next edge.
//    - After INIT, go to IDLE. Otherwise go to HOLD with cnt=0 and rep_first=1.
//    - Key activity is ignored while waiting; a release is seen in HOLD.
//  - HOLD:
//    - If ks[act]=0, go to DEB_REL with cnt=0.
//    - Otherwise count. At REPEAT_DELAY-1 (rep_first=1) or REPEAT_PERIOD-1 (rep_first=0): go to APPLY, clear rep_first.
//  - DEB_REL:
//    - If any ks bit is high, go back to HOLD with cnt=0 (treated as bounce).
//    - If all keys stay low for DEB_CYCLES cycles, go to IDLE.
//  - Keys other than act are ignored from DEB_PRESS until IDLE. Simultaneous presses resolve by priority.
//  - fw_ready while fw_valid=0 is ignored. One accepted word per APPLY; no word is skipped or duplicated.
//  - Counters are wide enough for the largest of DEB_CYCLES/REPEAT_DELAY/REPEAT_PERIOD.
//    Values < 1 are illegal.
// TESTING  (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, defaults otherwise; fw_ready=1 unless stated)
//  1. Reset release -> fw_valid=1 with fre_word=10 for one cycle, led=0, then IDLE with busy=0.
//  2. key[0] held 10 cycles, then released -> exactly one update 110, led[0]=1, busy=0 after release debounce.
//  3. key[2] held 60 cycles -> updates 20, 30, 40, 50 spaced per delay/period; led[2] toggles each step.
//  4. key[1] from 10 (stuck at FW_MIN) -> no update, no LED toggle; at 65530, key[0] -> 65535, then none.
//  5. key[3] 2-cycle glitch -> no update; key[0]+key[3] pressed together -> only the +100 step applies.
//  6. fw_ready=0 for 7 cycles after step -> fre_word/fw_valid stable; accepted once when fw_ready rises.
//     rst mid-WAIT_ACK -> fre_word=10, led=0, INIT re-announce.

Source files
------------

// File: rtl/fre_word_sequencer.sv
// Key-driven DDS frequency-word sequencer: debounced keys, saturating coarse/fine
// steps with hold auto-repeat, and a valid/ready hand-off of each new word.
module fre_word_sequencer #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned STEP_COARSE   = 100,
    parameter int unsigned STEP_FINE     = 10,
    parameter int unsigned FW_INIT       = 10,
    parameter int unsigned FW_MIN        = 0,
    parameter int unsigned FW_MAX        = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic        fw_ready,
    output logic [15:0] fre_word,
    output logic        fw_valid,
    output logic [3:0]  led,
    output logic        busy
);

    localparam int unsigned CNT_A   = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
    localparam int unsigned CNT_MAX = (CNT_A > REPEAT_PERIOD) ? CNT_A : REPEAT_PERIOD;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic [16:0]   STEP_C17 = 17'(STEP_COARSE);
    localparam logic [16:0]   STEP_F17 = 17'(STEP_FINE);
    localparam logic [16:0]   MAX17    = 17'(FW_MAX);
    localparam logic [16:0]   MIN17    = 17'(FW_MIN);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DEB_PRESS,
        S_APPLY,
        S_WAIT_ACK,
        S_HOLD,
        S_DEB_REL
    } state_t;

    state_t        state, state_n;
    logic [3:0]    ks_meta, ks;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    act, act_n;
    logic          rep_first, rep_first_n;
    logic          from_init, from_init_n;
    logic [15:0]   fre_word_n;
    logic          fw_valid_n;
    logic [3:0]    led_n;
    logic [1:0]    pick;
    logic [16:0]   step, sum, dif, nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ks_meta   <= '0;
            ks        <= '0;
            state     <= S_INIT;
            cnt       <= '0;
            act       <= '0;
            rep_first <= 1'b0;
            from_init <= 1'b0;
            fre_word  <= 16'(FW_INIT);
            fw_valid  <= 1'b0;
            led       <= '0;
        end else begin
            ks_meta   <= key;
            ks        <= ks_meta;
            state     <= state_n;
            cnt       <= cnt_n;
            act       <= act_n;
            rep_first <= rep_first_n;
            from_init <= from_init_n;
            fre_word  <= fre_word_n;
            fw_valid  <= fw_valid_n;
            led       <= led_n;
        end
    end

    always_comb begin
        pick = 2'd3;
        if (ks[0])      pick = 2'd0;
        else if (ks[1]) pick = 2'd1;
        else if (ks[2]) pick = 2'd2;

        // Even key indices step up, odd ones down; bit 16 of dif flags underflow.
        step = act[1] ? STEP_F17 : STEP_C17;
        sum  = {1'b0, fre_word} + step;
        dif  = {1'b0, fre_word} - step;
        if (!act[0]) nxt = (sum > MAX17) ? MAX17 : sum;
        else         nxt = (dif[16] || dif < MIN17) ? MIN17 : dif;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        act_n       = act;
        rep_first_n = rep_first;
        from_init_n = from_init;
        fre_word_n  = fre_word;
        fw_valid_n  = fw_valid;
        led_n       = led;
        case (state)
            S_INIT: begin
                fw_valid_n  = 1'b1;
                from_init_n = 1'b1;
                state_n     = S_WAIT_ACK;
            end
            S_IDLE: begin
                if (|ks) begin
                    act_n       = pick;
                    cnt_n       = '0;
                    rep_first_n = 1'b1;
                    state_n     = S_DEB_PRESS;
                end
            end
            S_DEB_PRESS: begin
                if (!ks[act]) begin
                    state_n = S_IDLE;
                end else if (cnt == DEB_LAST) begin
                    cnt_n   = '0;
                    state_n = S_APPLY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_APPLY: begin
                cnt_n = '0;
                if (nxt != {1'b0, fre_word}) begin
                    fre_word_n = nxt[15:0];
                    fw_valid_n = 1'b1;
                    led_n[act] = ~led[act];
                    state_n    = S_WAIT_ACK;
                end else begin
                    state_n = S_HOLD;
                end
            end
            S_WAIT_ACK: begin
                // rep_first is armed on press and cleared on the first repeat, so
                // only the step that follows the initial press waits REPEAT_DELAY.
                if (fw_ready) begin
                    fw_valid_n  = 1'b0;
                    from_init_n = 1'b0;
                    cnt_n       = '0;
                    state_n     = from_init ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (!ks[act]) begin
                    cnt_n   = '0;
                    state_n = S_DEB_REL;
                end else if (cnt == (rep_first ? RD_LAST : RP_LAST)) begin
                    cnt_n       = '0;
                    rep_first_n = 1'b0;
                    state_n     = S_APPLY;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DEB_REL: begin
                if (|ks) begin
                    cnt_n   = '0;
                    state_n = S_HOLD;
                end else if (cnt == DEB_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_INIT;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_fre_word_sequencer.sv
// Bench for fre_word_sequencer: directed scenarios plus random key episodes checked
// against a word-sequence model derived from hold length and clamp arithmetic.
module tb_fre_word_sequencer;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key = '0;
    logic        fw_ready = 1'b1;
    logic [15:0] fre_word;
    logic        fw_valid;
    logic [3:0]  led;
    logic        busy;

    fre_word_sequencer #(
        .DEB_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key(key),
        .fw_ready(fw_ready),
        .fre_word(fre_word),
        .fw_valid(fw_valid),
        .led(led),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] word;
        logic [3:0]  led;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_log[$];
    int         acc_time[$];
    int         cur_word   = 10;
    logic [3:0] cur_led    = '0;
    int         model_word = 10;
    logic [3:0] model_led  = '0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         ready_mode = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // fw_ready: 0 = always high, 1 = random, 2 = held low
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       fw_ready = 1'b1;
            1:       fw_ready = ($urandom_range(0, 2) == 0);
            default: fw_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fw_valid) begin
                check("valid_has_expected_word", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("fre_word", fre_word, exp_q[0].word);
                    check("led_with_word", led, exp_q[0].led);
                    if (fw_ready) begin
                        cur_word = exp_q[0].word;
                        cur_led  = exp_q[0].led;
                        acc_log.push_back(cur_word);
                        acc_time.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("held_word", fre_word, cur_word);
                check("held_led", led, cur_led);
            end
        end
    end

    // Effective-step count for a clean hold of h cycles with fw_ready high:
    // first step needs DEB+1 held cycles, repeats follow RD+2 then RP+2 apart.
    function automatic int steps_for_hold(input int h);
        int n;
        if (h < DEB + 1) return 0;
        n = 1;
        while (h >= DEB + 3 + RD + (RP + 2) * (n - 1)) n++;
        return n;
    endfunction

    task automatic press(input logic [3:0] mask, input int h);
        int   k, n, w, nx, st;
        exp_t e;
        k = 0;
        for (int i = 3; i >= 0; i--) if (mask[i]) k = i;
        n  = (mask == 0) ? 0 : steps_for_hold(h);
        st = (k < 2) ? 100 : 10;
        w  = model_word;
        for (int i = 0; i < n; i++) begin
            if (k % 2 == 0) nx = (w + st > 65535) ? 65535 : w + st;
            else            nx = (w - st < 0) ? 0 : w - st;
            if (nx == w) break;
            w = nx;
            model_led[k] = ~model_led[k];
            e.word = 16'(w);
            e.led  = model_led;
            exp_q.push_back(e);
        end
        model_word = w;
        key = mask;
        repeat (h) @(posedge clk);
        #1 key = '0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        while (busy !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", busy, 0);
        check("no_pending_words", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        exp_t e;
        ready_mode = 0;
        key = '0;
        rst = 1'b1;
        exp_q.delete();
        e.word = 16'd10;
        e.led  = 4'd0;
        exp_q.push_back(e);
        cur_word = 10; cur_led = '0; model_word = 10; model_led = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_fw_valid", fw_valid, 0);
        check("rst_fre_word", fre_word, 10);
        check("rst_led", led, 0);
        check("rst_busy", busy, 1);
        @(negedge clk);
        check("announce_valid", fw_valid, 1);
        check("announce_word", fre_word, 10);
        check("announce_busy", busy, 1);
        @(negedge clk);
        check("post_announce_valid", fw_valid, 0);
        check("post_announce_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] m;
        int         h, sm, base;

        reset_dut();

        // key[2] held: 20, 30, 40, 50 with first repeat after 22 cycles, then every 10
        acc_log.delete(); acc_time.delete();
        press(4'b0100, 55);
        wait_idle();
        check("fine_count", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            check("fine_w0", acc_log[0], 20);
            check("fine_w1", acc_log[1], 30);
            check("fine_w2", acc_log[2], 40);
            check("fine_w3", acc_log[3], 50);
            check("fine_gap0", acc_time[1] - acc_time[0], 22);
            check("fine_gap1", acc_time[2] - acc_time[1], 10);
            check("fine_gap2", acc_time[3] - acc_time[2], 10);
        end
        check("fine_led", led, 4'b0000);

        // key[0] short hold: single +100
        acc_log.delete();
        press(4'b0001, 10);
        wait_idle();
        check("coarse_count", acc_log.size(), 1);
        check("coarse_word", fre_word, 150);
        check("coarse_led", led, 4'b0001);

        // 2-cycle glitch on key[3]: nothing
        acc_log.delete();
        press(4'b1000, 2);
        wait_idle();
        check("glitch_count", acc_log.size(), 0);
        check("glitch_word", fre_word, 150);

        // key[0]+key[3] together: key[0] wins
        acc_log.delete();
        press(4'b1001, 10);
        wait_idle();
        check("prio_count", acc_log.size(), 1);
        check("prio_word", fre_word, 250);
        check("prio_led", led, 4'b0000);

        // key[1] down to FW_MIN, then pinned
        acc_log.delete();
        press(4'b0010, 50);
        wait_idle();
        check("down_count", acc_log.size(), 3);
        check("down_word", fre_word, 0);
        check("down_led", led, 4'b0010);
        acc_log.delete();
        press(4'b0010, 40);
        wait_idle();
        check("min_pinned_count", acc_log.size(), 0);
        check("min_pinned_led", led, 4'b0010);

        // climb to 65530, then saturate at 65535
        press(4'b0001, 6557);
        wait_idle();
        check("climb_word", fre_word, 65500);
        for (int i = 0; i < 3; i++) begin
            press(4'b0100, 10);
            wait_idle();
        end
        check("near_max_word", fre_word, 65530);
        check("near_max_led", led, 4'b0111);
        acc_log.delete();
        press(4'b0001, 40);
        wait_idle();
        check("sat_count", acc_log.size(), 1);
        check("sat_word", fre_word, 65535);
        check("sat_led", led, 4'b0110);
        acc_log.delete();
        press(4'b0001, 40);
        wait_idle();
        check("max_pinned_count", acc_log.size(), 0);

        // loader stall: word and valid stay put, one acceptance afterwards
        acc_log.delete();
        ready_mode = 2;
        press(4'b1000, 10);
        repeat (7) begin
            @(negedge clk);
            check("stall_valid", fw_valid, 1);
            check("stall_word", fre_word, 65525);
        end
        ready_mode = 0;
        wait_idle();
        check("stall_accept_count", acc_log.size(), 1);
        check("stall_led", led, 4'b1110);

        // reset while a word is waiting for acceptance
        ready_mode = 2;
        press(4'b0001, 10);
        @(negedge clk);
        check("pre_reset_valid", fw_valid, 1);
        check("pre_reset_word", fre_word, 65535);
        @(posedge clk);
        #1;
        reset_dut();

        // random episodes
        for (int e = 0; e < 40; e++) begin
            m  = 4'($urandom_range(1, 15));
            sm = ($urandom_range(0, 3) == 0) ? 1 : 0;
            h  = (sm != 0) ? $urandom_range(5, 26) : $urandom_range(0, 70);
            ready_mode = sm;
            repeat (2) @(posedge clk);
            #1;
            base = acc_log.size();
            press(m, h);
            wait_idle();
            ready_mode = 0;
            check("rand_model_word", fre_word, model_word);
            check("rand_model_led", led, model_led);
            if (h < DEB + 1) check("rand_short_no_word", acc_log.size() - base, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
